// File: rtl/quant_writeback_ctrl.sv
// quant_writeback_ctrl: drains a tile of 4-lane accumulator beats, saturates each lane to BIT_WIDTH bits and writes packed words.
// Define QUANT_SHIFT_EN to add a per-tile logical right shift (shift_i, sampled on start) applied before saturation.
module quant_writeback_ctrl #(
  parameter int BIT_WIDTH  = 8,
  parameter int ROWS       = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef QUANT_SHIFT_EN
  input  logic [4:0]              shift_i,
`endif
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic                    acc_valid_i,
  output logic                    acc_ready_o,
  input  logic [12*BIT_WIDTH-1:0] acc_data_i,
  output logic                    wr_en_o,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [4*BIT_WIDTH-1:0]  wr_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [7:0]              sat_count_o
);
  localparam int LW = 3*BIT_WIDTH;
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam logic [LW-1:0] QMAX = LW'((1 << BIT_WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e                 state_q, state_d;
  logic [RW-1:0]          row_q;
  logic [ADDR_WIDTH-1:0]  addr_q, wr_addr_q;
  logic [4*BIT_WIDTH-1:0] wr_data_q, q_data;
  logic [7:0]             sat_q, sat_d;
  logic [8:0]             sat_sum;
  logic [3:0]             over;
  logic [4:0]             sh;
  logic                   wr_en_q, accept, xfer, last;

  assign accept = state_q == IDLE && start_i;
  assign xfer   = state_q == RUN && acc_valid_i;
  assign last   = row_q == RW'(ROWS - 1);

`ifdef QUANT_SHIFT_EN
  logic [4:0] shift_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) shift_q <= '0;
    else if (accept) shift_q <= shift_i;
  assign sh = shift_q;
`else
  assign sh = '0;
`endif

  // a shift of LW or more already empties the lane, so no special case is needed
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [LW-1:0] v;
    assign v = acc_data_i[l*LW +: LW] >> sh;
    assign q_data[l*BIT_WIDTH +: BIT_WIDTH] = v < QMAX ? v[BIT_WIDTH-1:0] : QMAX[BIT_WIDTH-1:0];
    assign over[l] = v > QMAX;
  end

  assign sat_sum = {1'b0, sat_q} + 9'($countones(over));
  assign sat_d   = sat_sum[8] ? 8'hFF : sat_sum[7:0];

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;

  always_comb
    state_d = accept ? RUN :
              (xfer && last) ? FLUSH :
              state_q == FLUSH ? DONE :
              state_q == DONE ? IDLE : state_q;

  always_comb begin
    acc_ready_o = state_q == RUN;
    busy_o      = state_q != IDLE;
    done_o      = state_q == DONE;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row_q     <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      sat_q     <= '0;
    end else begin
      wr_en_q <= xfer;
      if (accept) begin
        row_q  <= '0;
        addr_q <= base_addr_i;
        sat_q  <= '0;
      end else if (xfer) begin
        row_q     <= row_q + 1'b1;
        addr_q    <= addr_q + 1'b1;
        wr_addr_q <= addr_q;
        wr_data_q <= q_data;
        sat_q     <= sat_d;
      end
    end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign sat_count_o = sat_q;
endmodule

// File: tb/tb_quant_writeback_ctrl.sv
// tb_quant_writeback_ctrl: directed and randomized tiles checked against a lane-arithmetic reference model.
module tb_quant_writeback_ctrl;
  localparam int ROWS = 4;

  logic        clk = 0, rst = 1, start = 0, acc_valid = 0;
  logic [7:0]  base_addr = 0;
  logic [95:0] acc_data = 0;
  logic [4:0]  shift = 0;
  logic        acc_ready, wr_en, busy, done;
  logic [7:0]  wr_addr, sat_count;
  logic [31:0] wr_data;

  int checks = 0, errors = 0, cyc = 0, busy_err = 0;
  bit tile_active = 0;
  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  logic [95:0] beats[ROWS];

  quant_writeback_ctrl #(.BIT_WIDTH(8), .ROWS(ROWS), .ADDR_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
`ifdef QUANT_SHIFT_EN
    .shift_i(shift),
`endif
    .start_i(start),
    .base_addr_i(base_addr),
    .acc_valid_i(acc_valid),
    .acc_ready_o(acc_ready),
    .acc_data_i(acc_data),
    .wr_en_o(wr_en),
    .wr_addr_o(wr_addr),
    .wr_data_o(wr_data),
    .busy_o(busy),
    .done_o(done),
    .sat_count_o(sat_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst) begin
      if (wr_en) begin
        wa.push_back(wr_addr);
        wd.push_back(wr_data);
        wc.push_back(cyc);
      end
      if (tile_active && !busy) busy_err <= busy_err + 1;
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // each lane: divide by 2^shift, clip to 255, count lanes strictly above 255
  function automatic void model(input logic [95:0] b, input int sh, output logic [31:0] d, output int ns);
    d = '0;
    ns = 0;
    for (int l = 0; l < 4; l++) begin
      int v, s;
      v = int'(b[24*l +: 24]);
      s = sh >= 24 ? 0 : v / (1 << sh);
      d[8*l +: 8] = 8'(s > 255 ? 255 : s);
      ns += int'(s > 255);
    end
  endfunction

  function automatic logic [23:0] rnd_lane();
    case ($urandom_range(0, 3))
      0: return 24'($urandom_range(0, 254));
      1: return 24'($urandom_range(254, 256));
      2: return 24'($urandom);
      default: return 24'($urandom_range(0, 8191));
    endcase
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, " acc_ready"}, acc_ready, 0);
    chk({tag, " wr_en"}, wr_en, 0);
    chk({tag, " wr_addr"}, wr_addr, 0);
    chk({tag, " wr_data"}, wr_data, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " sat_count"}, sat_count, 0);
  endtask

  task automatic run_tile(input string tag, input logic [7:0] base, input int gap, input bit mid, input int sh);
    int i0, be0, sent, t, sc, dc, ns, nsat, exp_sat;
    bit xf, ph;
    logic [31:0] d;
    i0 = wa.size();
    be0 = busy_err;
    nsat = 0;
    start = 1;
    base_addr = base;
    shift = 5'(sh);
    @(posedge clk); #1;
    start = 0;
    sc = cyc;
    tile_active = 1;
    sent = 0;
    t = 0;
    ph = 1;
    while (sent < ROWS && t < 200) begin
      acc_valid = gap == 0 ? 1'b1 : gap == 1 ? ph : 1'($urandom_range(0, 1));
      ph = !ph;
      acc_data = beats[sent];
      start = mid && t == 2;
      base_addr = start ? base + 8'h40 : base;
      shift = start ? 5'(sh) ^ 5'h1F : 5'(sh);
      @(negedge clk);
      xf = acc_valid && acc_ready;
      @(posedge clk); #1;
      sent += int'(xf);
      t++;
    end
    acc_valid = 0;
    start = 0;
    chk({tag, " beats accepted"}, sent, ROWS);
    t = 0;
    do begin @(negedge clk); t++; end while (!done && t < 12);
    dc = cyc;
    tile_active = 0;
    chk({tag, " done seen"}, done, 1);
    chk({tag, " write count"}, wa.size() - i0, ROWS);
    for (int k = 0; k < ROWS && i0 + k < wa.size(); k++) begin
      model(beats[k], sh, d, ns);
      nsat += ns;
      chk({tag, " addr"}, wa[i0+k], 8'(base + k));
      chk({tag, " data"}, wd[i0+k], d);
    end
    if (wa.size() > i0) begin
      chk({tag, " done after last write"}, dc, wc[$] + 1);
      chk({tag, " addr hold"}, wr_addr, wa[$]);
      chk({tag, " data hold"}, wr_data, wd[$]);
    end
    exp_sat = nsat > 255 ? 255 : nsat;
    chk({tag, " sat_count"}, sat_count, exp_sat);
    chk({tag, " busy gap"}, busy_err - be0, 0);
    if (gap == 0) chk({tag, " min duration"}, dc, sc + ROWS + 1);
    @(negedge clk);
    chk({tag, " busy idle"}, busy, 0);
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " sat hold"}, sat_count, exp_sat);
  endtask

  initial begin
    int n0, sh;
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #2 rst = 0;

    beats[0] = {4{24'h000012}};
    beats[1] = {4{24'h000034}};
    beats[2] = {4{24'h000056}};
    beats[3] = {4{24'h000078}};
    run_tile("basic", 8'h10, 0, 0, 0);
    chk("basic first word", wd[wd.size()-4], 32'h12121212);
    chk("basic last word", wd[wd.size()-1], 32'h78787878);

    beats[0] = {24'hFFFFFF, 24'h000100, 24'h0000FF, 24'h0000FE};
    for (int r = 1; r < ROWS; r++) beats[r] = '0;
    run_tile("sat", 8'h20, 0, 0, 0);
    chk("sat word", wd[wd.size()-4], 32'hFFFFFFFE);
    chk("sat count", sat_count, 2);

    for (int r = 0; r < ROWS; r++) beats[r] = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
    run_tile("gaps", 8'h50, 1, 1, 0);

    for (int r = 0; r < ROWS; r++) beats[r] = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
    run_tile("wrap", 8'hFE, 0, 0, 0);
    chk("wrap third addr", wa[wa.size()-2], 8'h00);

    n0 = wa.size();
    acc_valid = 1;
    acc_data = {4{24'hFFFFFF}};
    repeat (5) @(negedge clk);
    chk("idle valid writes", wa.size() - n0, 0);
    chk("idle valid ready", acc_ready, 0);
    acc_valid = 0;

    for (int r = 0; r < ROWS; r++) beats[r] = {4{24'h000300}};
    start = 1;
    base_addr = 8'h33;
    @(posedge clk); #1;
    start = 0;
    acc_valid = 1;
    acc_data = beats[0];
    @(posedge clk); #1;
    acc_data = beats[1];
    @(posedge clk); #1;
    acc_valid = 0;
    chk("rst inflight wr_en", wr_en, 1);
    #2 rst = 1;
    #1 chk_reset("rst async");
    @(posedge clk); #2 rst = 0;
    for (int r = 0; r < ROWS; r++) beats[r] = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
    run_tile("after rst", 8'hA0, 0, 0, 0);

`ifdef QUANT_SHIFT_EN
    beats[0] = {24'h00000F, 24'h000010, 24'h001000, 24'h000FF0};
    for (int r = 1; r < ROWS; r++) beats[r] = '0;
    run_tile("shift", 8'h60, 0, 0, 4);
    chk("shift word", wd[wd.size()-4], 32'h0001FFFF);
    chk("shift sat", sat_count, 1);
`endif

    for (int i = 0; i < 20; i++) begin
      for (int r = 0; r < ROWS; r++) beats[r] = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
`ifdef QUANT_SHIFT_EN
      sh = $urandom_range(0, 31);
`else
      sh = 0;
`endif
      run_tile("rand", 8'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)), sh);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/quant_writeback_ctrl.md
# quant_writeback_ctrl

Sequencer that drains one tile of accumulator results from the systolic array, quantizes each 24-bit lane to 8 bits and writes packed 32-bit words into the output buffer. It sits between the accumulator bank and the output SRAM. It owns the start/done handshake with the top-level TPU controller, the write-address generation and the per-tile saturation statistics.

## Interface
- BIT_WIDTH, 8: quantized lane width; accumulator lane width is 3*BIT_WIDTH.
- ROWS, 4: accumulator beats (rows) per tile; must be ≥1.
- ADDR_WIDTH, 8: output buffer address width.

- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a tile when in IDLE.
- base_addr  in  ADDR_WIDTH  first write address; sampled on the accepted start.
- acc_valid  in  1  accumulator beat valid.
- acc_ready  out  1  controller accepts a beat.
- acc_data  in  12*BIT_WIDTH  four unsigned lanes; lane0 = bits [3*BIT_WIDTH-1:0], lane3 in the MSBs.
- wr_en  out  1  output buffer write strobe.
- wr_addr  out  ADDR_WIDTH  write address.
- wr_data  out  4*BIT_WIDTH  packed bytes, lane0 in the LSBs.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at tile completion.
- sat_count  out  8  number of clipped lanes in the current/last tile.
- shift  in  5  right-shift amount; present only with QUANT_SHIFT_EN.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE → RUN on start.
  - Latches base_addr into the address pointer.
  - Clears the row counter and sat_count.
- Start is ignored in every state other than IDLE.
- RUN:
  - acc_ready=1.
  - A beat transfers when acc_valid && acc_ready.
  - Each transfer increments the row counter.
  - The transfer of beat ROWS-1 moves the FSM to FLUSH and drops acc_ready in the same edge.
- FLUSH: waits one cycle for the final write to issue, then goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Quantize each lane v (unsigned, 3*BIT_WIDTH bits):
  - q = v if v < 2^BIT_WIDTH − 1.
  - q = 2^BIT_WIDTH − 1 otherwise.
- sat_count:
  - Increments by the number of lanes in the beat with v > 2^BIT_WIDTH − 1 (0–4 per beat).
  - Saturates at 255.
  - Holds its value after done until the next accepted start.
- Address pointer: increments by 1 per write and wraps modulo 2^ADDR_WIDTH.
- The output buffer always accepts writes; there is no write backpressure.

## Timing
- Reset values: FSM=IDLE, acc_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, sat_count=0.
- Write latency is one cycle: a beat transferred at edge t produces wr_en=1 with its wr_addr/wr_data during the cycle after t.
- wr_en is high only in cycles following a transfer; wr_data and wr_addr hold their values when wr_en=0.
- Back-to-back beats produce back-to-back writes at consecutive addresses.
- Minimum tile duration with acc_valid held high: start edge, then ROWS RUN cycles, 1 FLUSH cycle and 1 DONE cycle.
- busy is high in RUN, FLUSH and DONE.
- done is asserted in the cycle after the last wr_en.
- Reset mid-tile aborts immediately: all outputs take their reset values and the in-flight write is dropped.
- acc_valid while not in RUN has no effect: no transfer, no count.

## Configuration
- QUANT_SHIFT_EN defined:
  - Port shift is present and is sampled on the accepted start.
  - Each lane is computed as v >> shift (logical) before saturation and saturation counting.
  - Shift values ≥ 3*BIT_WIDTH yield 0.
- QUANT_SHIFT_EN undefined: no shift port; lanes are saturated directly (shift = 0).

## Test plan
- Basic tile:
  - Stimulus: ROWS=4, base_addr=0x10; beats with every lane equal to 0x000012, 0x000034, 0x000056, 0x000078.
  - Required: writes to 0x10–0x13 with data 0x12121212, 0x34343434, 0x56565656, 0x78787878; done one cycle after the last write; sat_count=0.
- Saturation:
  - Stimulus: one beat with lanes 0x0000FE, 0x0000FF, 0x000100, 0xFFFFFF.
  - Required: wr_data=0xFFFFFFFE (lane0=0xFE, lanes1–3=0xFF); sat_count=2.
- Backpressure gaps and ignored start:
  - Stimulus: acc_valid toggles 1,0,1,0,…; start is pulsed mid-RUN.
  - Required: exactly 4 writes, no duplicated addresses, the mid-RUN start has no effect, busy stays high until done.
- Address wrap:
  - Stimulus: base_addr=0xFE, 4 beats.
  - Required: addresses 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-tile:
  - Stimulus: assert rst after 2 beats.
  - Required: all outputs return to reset values asynchronously; a new start runs a full 4-write tile from the new base_addr.
- Shift (QUANT_SHIFT_EN):
  - Stimulus: shift=4; lanes 0x000FF0, 0x001000, 0x000010, 0x00000F.
  - Required: wr_data=0x0001FFFF (lane0=0xFF, lane1=0xFF, lane2=0x01, lane3=0x00); sat_count=1.
